// File: rtl/exa_crosb_output_vc_credit_tracker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : exanet_crosb_pkg                                              |
// | Purpose  : Shared types and defaults for the crossbar output-VC credit   |
// |            tracker: per-VC state encoding, default downstream depth and  |
// |            a counter-width helper.                                       |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package exanet_crosb_pkg;

  // Per-VC ownership state: free, owned but no flit sent, mid-packet.
  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_ALLOC  = 2'd1,
    VC_ACTIVE = 2'd2
  } vc_state_t;

  // Default downstream buffer depth per VC, in flits.
  localparam int CREDIT_MAX_DEFAULT = 16;

  // Bits needed to hold 0..max inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/exa_crosb_output_vc_credit_tracker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: exa_crosb_output_vc_credit_tracker_if                         |
// | Purpose  : Bundles the allocation request, link monitor, credit return   |
// |            and per-VC status outputs of the credit tracker.              |
// | Ports    : alloc  - i_alloc_valid/vc/input, o_alloc_grant                |
// |            link   - i_flit_valid/ready/last/vc                           |
// |            credit - i_credit_valid/vc                                    |
// |            status - o_vc_busy, o_credit_avail, o_credit_cnt, o_vc_owner, |
// |                     o_err_overflow/underflow/protocol                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface exa_crosb_output_vc_credit_tracker_if #(
  parameter int VCS       = 4,
  parameter int logVcPrio = 2,
  parameter int logIn     = 1,
  parameter int CNT_W     = 5
);
  logic                           i_alloc_valid;
  logic [logVcPrio-1:0]           i_alloc_vc;
  logic [logIn-1:0]               i_alloc_input;
  logic                           o_alloc_grant;

  logic                           i_flit_valid;
  logic                           i_flit_ready;
  logic                           i_flit_last;
  logic [logVcPrio-1:0]           i_flit_vc;

  logic                           i_credit_valid;
  logic [logVcPrio-1:0]           i_credit_vc;

  logic [VCS-1:0]                 o_vc_busy;
  logic [VCS-1:0]                 o_credit_avail;
  logic [VCS-1:0][CNT_W-1:0]      o_credit_cnt;
  logic [VCS-1:0][logIn-1:0]      o_vc_owner;
  logic                           o_err_overflow;
  logic                           o_err_underflow;
  logic                           o_err_protocol;

  // Environment side: drives requests, link monitor and credit returns.
  modport master (
    output i_alloc_valid, i_alloc_vc, i_alloc_input,
    output i_flit_valid, i_flit_ready, i_flit_last, i_flit_vc,
    output i_credit_valid, i_credit_vc,
    input  o_alloc_grant, o_vc_busy, o_credit_avail, o_credit_cnt, o_vc_owner,
    input  o_err_overflow, o_err_underflow, o_err_protocol
  );

  // Tracker side.
  modport slave (
    input  i_alloc_valid, i_alloc_vc, i_alloc_input,
    input  i_flit_valid, i_flit_ready, i_flit_last, i_flit_vc,
    input  i_credit_valid, i_credit_vc,
    output o_alloc_grant, o_vc_busy, o_credit_avail, o_credit_cnt, o_vc_owner,
    output o_err_overflow, o_err_underflow, o_err_protocol
  );
endinterface
`default_nettype wire

// File: rtl/exa_crosb_output_vc_credit_tracker_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exa_crosb_vc_credit_counter                                   |
// | Purpose  : Saturating up/down credit counter for one VC, reset to full.  |
// | Ports    : clk, resetn  - clock, synchronous active-low reset            |
// |            dec_i        - one flit sent on this VC (consumes a credit)   |
// |            inc_i        - one credit returned for this VC                |
// |            cnt_o        - current credit count                           |
// |            underflow_o  - flit sent while count is 0 (pulse)             |
// |            overflow_o   - credit returned while full, no flit (pulse)    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module exa_crosb_vc_credit_counter
  import exanet_crosb_pkg::*;
#(
  parameter int CREDIT_MAX = CREDIT_MAX_DEFAULT,
  parameter int CNT_W      = cnt_width(CREDIT_MAX)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             underflow_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(CREDIT_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    // Spending a credit we do not have is flagged even if a return
    // lands in the same cycle; the count itself nets to unchanged.
    if (dec_i && (cnt_q == '0)) begin
      underflow_o = 1'b1;
    end
    if (dec_i && !inc_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (inc_i && !dec_i) begin
      if (cnt_q == C_MAX_CNT) begin
        overflow_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= C_MAX_CNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/exa_crosb_output_vc_credit_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exa_crosb_output_vc_credit_tracker                            |
// | Purpose  : Tracks ownership and downstream credits of every output VC of |
// |            one crossbar output port; grants VC allocation requests.      |
// | Ports    : clk, resetn - clock, synchronous active-low reset             |
// |            bus (slave) - allocation request/grant, output link monitor,  |
// |                          credit return, per-VC status and sticky errors  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module exa_crosb_output_vc_credit_tracker
  import exanet_crosb_pkg::*;
#(
  parameter int OUTPUT_PORT_NUMBER = 0,
  parameter int input_num          = 2,
  parameter int vc_num             = 2,
  parameter int prio_num           = 2,
  parameter int CREDIT_MAX         = CREDIT_MAX_DEFAULT,
  parameter int VCS                = vc_num * prio_num,
  parameter int logVcPrio          = $clog2(VCS),
  parameter int logIn              = $clog2(input_num),
  parameter int CNT_W              = cnt_width(CREDIT_MAX)
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  exa_crosb_output_vc_credit_tracker_if.slave   bus
);

  if (OUTPUT_PORT_NUMBER < 0 || input_num < 2 || VCS < 2 || CREDIT_MAX < 1) begin : g_param_chk
    $error("exa_crosb_output_vc_credit_tracker: illegal parameter set");
  end

  vc_state_t                 state_q [VCS];
  vc_state_t                 state_d [VCS];
  logic [VCS-1:0][logIn-1:0] owner_q;
  logic [VCS-1:0][logIn-1:0] owner_d;
  logic [VCS-1:0][CNT_W-1:0] cnt;
  logic [VCS-1:0]            dec;
  logic [VCS-1:0]            inc;
  logic [VCS-1:0]            underflow;
  logic [VCS-1:0]            overflow;
  logic [VCS-1:0]            busy;
  logic [VCS-1:0]            avail;
  logic                      fire;
  logic                      grant;
  logic                      proto_hit;
  logic                      err_of_q, err_of_d;
  logic                      err_uf_q, err_uf_d;
  logic                      err_pr_q, err_pr_d;

  assign fire = bus.i_flit_valid & bus.i_flit_ready;

  // Zero-latency grant. Busy state is registered, so a VC released by its
  // last flit only looks IDLE from the following cycle on.
  assign grant = resetn & bus.i_alloc_valid
               & (state_q[bus.i_alloc_vc] == VC_IDLE)
               & (cnt[bus.i_alloc_vc] != '0);

  assign proto_hit = fire & (state_q[bus.i_flit_vc] == VC_IDLE);

  for (genvar v = 0; v < VCS; v++) begin : g_vc
    assign dec[v]   = fire & (bus.i_flit_vc == logVcPrio'(v));
    assign inc[v]   = bus.i_credit_valid & (bus.i_credit_vc == logVcPrio'(v));
    assign busy[v]  = (state_q[v] != VC_IDLE);
    assign avail[v] = (cnt[v] != '0);

    exa_crosb_vc_credit_counter #(
      .CREDIT_MAX (CREDIT_MAX),
      .CNT_W      (CNT_W)
    ) u_credit_cnt (
      .clk         (clk),
      .resetn      (resetn),
      .dec_i       (dec[v]),
      .inc_i       (inc[v]),
      .cnt_o       (cnt[v]),
      .underflow_o (underflow[v]),
      .overflow_o  (overflow[v])
    );
  end

  always_comb begin
    for (int v = 0; v < VCS; v++) begin
      state_d[v] = state_q[v];
      owner_d[v] = owner_q[v];
      case (state_q[v])
        VC_IDLE: begin
          // A flit on an IDLE VC is a protocol error only; state is kept.
          if (grant && (bus.i_alloc_vc == logVcPrio'(v))) begin
            state_d[v] = VC_ALLOC;
            owner_d[v] = bus.i_alloc_input;
          end
        end
        VC_ALLOC: begin
          if (dec[v]) begin
            state_d[v] = bus.i_flit_last ? VC_IDLE : VC_ACTIVE;
          end
        end
        VC_ACTIVE: begin
          if (dec[v] && bus.i_flit_last) begin
            state_d[v] = VC_IDLE;
          end
        end
        default: state_d[v] = VC_IDLE;
      endcase
    end
  end

  assign err_of_d = err_of_q | (|overflow);
  assign err_uf_d = err_uf_q | (|underflow);
  assign err_pr_d = err_pr_q | proto_hit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int v = 0; v < VCS; v++) begin
        state_q[v] <= VC_IDLE;
      end
      owner_q  <= '0;
      err_of_q <= 1'b0;
      err_uf_q <= 1'b0;
      err_pr_q <= 1'b0;
    end else begin
      for (int v = 0; v < VCS; v++) begin
        state_q[v] <= state_d[v];
      end
      owner_q  <= owner_d;
      err_of_q <= err_of_d;
      err_uf_q <= err_uf_d;
      err_pr_q <= err_pr_d;
    end
  end

  assign bus.o_alloc_grant   = grant;
  assign bus.o_vc_busy       = busy;
  assign bus.o_credit_avail  = avail;
  assign bus.o_credit_cnt    = cnt;
  assign bus.o_vc_owner      = owner_q;
  assign bus.o_err_overflow  = err_of_q;
  assign bus.o_err_underflow = err_uf_q;
  assign bus.o_err_protocol  = err_pr_q;

endmodule
`default_nettype wire

// File: tb/tb_exa_crosb_output_vc_credit_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_exa_crosb_output_vc_credit_tracker                         |
// | Purpose  : Self-checking bench for the output-VC credit tracker with a   |
// |            behavioural model (ownership flags and integer credit pool). |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_exa_crosb_output_vc_credit_tracker;

  localparam int NV   = 4;
  localparam int CMAX = 16;

  logic clk;
  logic resetn;

  exa_crosb_output_vc_credit_tracker_if #(
    .VCS(NV), .logVcPrio(2), .logIn(1), .CNT_W(5)
  ) bus ();

  exa_crosb_output_vc_credit_tracker #(
    .OUTPUT_PORT_NUMBER(0), .input_num(2), .vc_num(2), .prio_num(2), .CREDIT_MAX(CMAX)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns each VC, how many credits it has, errors.
  bit m_owned  [NV];
  int m_credit [NV];
  int m_owner  [NV];
  bit m_of, m_uf, m_pr;

  bit obs_grant;
  bit exp_grant;

  function automatic void model_step(bit rn, bit av, int avc, int ain, bit fv, bit fr,
                                     bit fl, int fvc, bit cv, int cvc);
    bit g;
    bit f;
    if (!rn) begin
      for (int v = 0; v < NV; v++) begin
        m_owned[v] = 0; m_credit[v] = CMAX; m_owner[v] = 0;
      end
      m_of = 0; m_uf = 0; m_pr = 0;
      return;
    end
    g = av && !m_owned[avc] && (m_credit[avc] > 0);
    f = fv && fr;
    for (int v = 0; v < NV; v++) begin
      bit spend;
      bit give;
      spend = f && (fvc == v);
      give  = cv && (cvc == v);
      if (spend && m_credit[v] == 0) m_uf = 1;
      if (spend && !give && m_credit[v] > 0) m_credit[v] = m_credit[v] - 1;
      if (give && !spend) begin
        if (m_credit[v] == CMAX) m_of = 1;
        else m_credit[v] = m_credit[v] + 1;
      end
    end
    if (f) begin
      if (!m_owned[fvc]) m_pr = 1;
      else if (fl) m_owned[fvc] = 0;
    end
    if (g) begin
      m_owned[avc] = 1;
      m_owner[avc] = ain;
    end
  endfunction

  function automatic logic [NV-1:0] exp_busy();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = m_owned[v];
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_avail();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = (m_credit[v] != 0);
    return r;
  endfunction

  function automatic logic [NV-1:0][4:0] exp_cnt();
    logic [NV-1:0][4:0] r;
    for (int v = 0; v < NV; v++) r[v] = 5'(m_credit[v]);
    return r;
  endfunction

  function automatic logic [NV-1:0][0:0] exp_owner();
    logic [NV-1:0][0:0] r;
    for (int v = 0; v < NV; v++) r[v] = 1'(m_owner[v]);
    return r;
  endfunction

  // One clock cycle: apply inputs, sample the grant mid-cycle, advance model.
  task automatic step(bit rn, bit av, int avc, int ain, bit fv, bit fr,
                      bit fl, int fvc, bit cv, int cvc);
    resetn             = rn;
    bus.i_alloc_valid  = av;
    bus.i_alloc_vc     = 2'(avc);
    bus.i_alloc_input  = 1'(ain);
    bus.i_flit_valid   = fv;
    bus.i_flit_ready   = fr;
    bus.i_flit_last    = fl;
    bus.i_flit_vc      = 2'(fvc);
    bus.i_credit_valid = cv;
    bus.i_credit_vc    = 2'(cvc);
    #4;
    obs_grant = bus.o_alloc_grant;
    exp_grant = rn && av && !m_owned[avc] && (m_credit[avc] > 0);
    @(posedge clk);
    model_step(rn, av, avc, ain, fv, fr, fl, fvc, cv, cvc);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_grant !== 1'b0) begin
      bad++; $display("FAIL reset_grant: got %0b want 0", obs_grant);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (bus.o_credit_cnt !== {5'd16, 5'd16, 5'd16, 5'd16}) begin
      bad++; $display("FAIL reset_cnt: got %h want all 16", bus.o_credit_cnt);
    end
    total++;
    if (bus.o_vc_busy !== 4'h0 || bus.o_credit_avail !== 4'hF) begin
      bad++; $display("FAIL reset_busy_avail: got busy=%h avail=%h want 0/f",
                      bus.o_vc_busy, bus.o_credit_avail);
    end
    total++;
    if ({bus.o_err_overflow, bus.o_err_underflow, bus.o_err_protocol} !== 3'b000) begin
      bad++; $display("FAIL reset_err: got %b want 000",
                      {bus.o_err_overflow, bus.o_err_underflow, bus.o_err_protocol});
    end
  endtask

  task automatic test_alloc();
    step(1, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_grant !== 1'b1) begin
      bad++; $display("FAIL alloc_grant: got %0b want 1", obs_grant);
    end
    total++;
    if (bus.o_vc_busy[2] !== 1'b1 || bus.o_vc_owner[2] !== 1'b1) begin
      bad++; $display("FAIL alloc_owner: got busy=%0b owner=%0b want 1/1",
                      bus.o_vc_busy[2], bus.o_vc_owner[2]);
    end
    step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_grant !== 1'b0) begin
      bad++; $display("FAIL alloc_regrant: got %0b want 0", obs_grant);
    end
  endtask

  task automatic test_packet();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    total++;
    if (obs_grant !== 1'b0) begin
      bad++; $display("FAIL packet_last_cycle_grant: got %0b want 0", obs_grant);
    end
    total++;
    if (bus.o_credit_cnt[0] !== 5'd12 || bus.o_vc_busy[0] !== 1'b0) begin
      bad++; $display("FAIL packet_release: got cnt=%0d busy=%0b want 12/0",
                      bus.o_credit_cnt[0], bus.o_vc_busy[0]);
    end
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_grant !== 1'b1) begin
      bad++; $display("FAIL packet_regrant: got %0b want 1", obs_grant);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 1, 1, 0, 3, 0, 0);
    total++;
    if (bus.o_credit_cnt[1] !== 5'd5 || bus.o_credit_cnt[3] !== 5'd14) begin
      bad++; $display("FAIL b2b_setup: got vc1=%0d vc3=%0d want 5/14",
                      bus.o_credit_cnt[1], bus.o_credit_cnt[3]);
    end
    step(1, 0, 0, 0, 1, 1, 0, 1, 1, 1);
    total++;
    if (bus.o_credit_cnt[1] !== 5'd5) begin
      bad++; $display("FAIL b2b_same_vc: got %0d want 5", bus.o_credit_cnt[1]);
    end
    step(1, 0, 0, 0, 1, 1, 0, 1, 1, 3);
    total++;
    if (bus.o_credit_cnt[1] !== 5'd4 || bus.o_credit_cnt[3] !== 5'd15) begin
      bad++; $display("FAIL b2b_diff_vc: got vc1=%0d vc3=%0d want 4/15",
                      bus.o_credit_cnt[1], bus.o_credit_cnt[3]);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 1, 1, 0, 3, 0, 0);
    step(1, 0, 0, 0, 1, 1, 1, 3, 0, 0);
    total++;
    if (bus.o_credit_cnt[3] !== 5'd0 || bus.o_err_underflow !== 1'b1 ||
        bus.o_credit_avail[3] !== 1'b0) begin
      bad++; $display("FAIL underflow: got cnt=%0d uf=%0b avail=%0b want 0/1/0",
                      bus.o_credit_cnt[3], bus.o_err_underflow, bus.o_credit_avail[3]);
    end
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_grant !== 1'b0) begin
      bad++; $display("FAIL no_credit_grant: got %0b want 0", obs_grant);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    total++;
    if (bus.o_credit_cnt[0] !== 5'd16 || bus.o_err_overflow !== 1'b0) begin
      bad++; $display("FAIL refill: got cnt=%0d of=%0b want 16/0",
                      bus.o_credit_cnt[0], bus.o_err_overflow);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    total++;
    if (bus.o_credit_cnt[0] !== 5'd16 || bus.o_err_overflow !== 1'b1) begin
      bad++; $display("FAIL overflow: got cnt=%0d of=%0b want 16/1",
                      bus.o_credit_cnt[0], bus.o_err_overflow);
    end
  endtask

  task automatic test_reset_mid_packet();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    total++;
    if (bus.o_credit_cnt[1] !== 5'd7 || bus.o_vc_busy[1] !== 1'b1 ||
        bus.o_vc_owner[1] !== 1'b1) begin
      bad++; $display("FAIL midrst_setup: got cnt=%0d busy=%0b owner=%0b want 7/1/1",
                      bus.o_credit_cnt[1], bus.o_vc_busy[1], bus.o_vc_owner[1]);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (bus.o_vc_busy[1] !== 1'b0 || bus.o_credit_cnt[1] !== 5'd16 ||
        bus.o_vc_owner[1] !== 1'b0) begin
      bad++; $display("FAIL midrst: got busy=%0b cnt=%0d owner=%0b want 0/16/0",
                      bus.o_vc_busy[1], bus.o_credit_cnt[1], bus.o_vc_owner[1]);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
      total++;
      if (obs_grant !== exp_grant) begin
        bad++; $display("FAIL rnd_grant[%0d]: got %0b want %0b", n, obs_grant, exp_grant);
      end
      total++;
      if (bus.o_vc_busy !== exp_busy() || bus.o_credit_avail !== exp_avail()) begin
        bad++; $display("FAIL rnd_busy_avail[%0d]: got %h/%h want %h/%h", n,
                        bus.o_vc_busy, bus.o_credit_avail, exp_busy(), exp_avail());
      end
      total++;
      if (bus.o_credit_cnt !== exp_cnt()) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got %h want %h", n, bus.o_credit_cnt, exp_cnt());
      end
      total++;
      if (bus.o_vc_owner !== exp_owner()) begin
        bad++; $display("FAIL rnd_owner[%0d]: got %h want %h", n, bus.o_vc_owner, exp_owner());
      end
      total++;
      if ({bus.o_err_overflow, bus.o_err_underflow, bus.o_err_protocol} !== {m_of, m_uf, m_pr}) begin
        bad++; $display("FAIL rnd_err[%0d]: got %b want %b", n,
                        {bus.o_err_overflow, bus.o_err_underflow, bus.o_err_protocol},
                        {m_of, m_uf, m_pr});
      end
    end
  endtask

  initial begin
    resetn             = 1'b0;
    bus.i_alloc_valid  = 1'b0;
    bus.i_alloc_vc     = '0;
    bus.i_alloc_input  = '0;
    bus.i_flit_valid   = 1'b0;
    bus.i_flit_ready   = 1'b0;
    bus.i_flit_last    = 1'b0;
    bus.i_flit_vc      = '0;
    bus.i_credit_valid = 1'b0;
    bus.i_credit_vc    = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_alloc();
    test_packet();
    test_back_to_back();
    test_saturation();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
